// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
//
// Purpose: bundles the upstream (decode register) and downstream (ID/EX
// register) valid/ready handshakes of imm_gen_pipe into one interface.
//
// Parameters:
//   XLEN  - datapath width of the extended immediate (32 or 64)
//   TAG_W - width of the sideband tag carried with each result
//
// Signals:
//   in_valid    producer -> block  instruction/imm_sel/tag_in are valid
//   in_ready    block -> producer  block can accept an entry this cycle
//   instruction producer -> block  raw 32-bit instruction word
//   imm_sel     producer -> block  immediate format select
//   tag_in      producer -> block  sideband tag, passed through unmodified
//   out_valid   block -> consumer  imm_out/tag_out/shamt_err are valid
//   out_ready   consumer -> block  consumer accepts the output this cycle
//   imm_out     block -> consumer  extended immediate
//   tag_out     block -> consumer  tag associated with imm_out
//   shamt_err   block -> consumer  illegal shift amount for XLEN=32
//
// Modports:
//   slave  - the immediate generator itself
//   master - the surrounding pipeline (producer and consumer side)
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [2:0]       imm_sel;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic [TAG_W-1:0] tag_out;
    logic             shamt_err;

    modport slave (
        input  in_valid, instruction, imm_sel, tag_in, out_ready,
        output in_ready, out_valid, imm_out, tag_out, shamt_err
    );

    modport master (
        output in_valid, instruction, imm_sel, tag_in, out_ready,
        input  in_ready, out_valid, imm_out, tag_out, shamt_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Purpose: registered immediate generator for the decode stage. Extracts and
// extends every RV32I/RV64I immediate format (I, S, B, U, J, shift amount,
// CSR zimm) to XLEN bits and carries a caller tag alongside each result
// through a 2-entry skid buffer (output register + skid register) with
// valid/ready handshakes on both sides. Output order is strict FIFO.
//
// Parameters:
//   XLEN  - datapath width, 32 or 64
//   TAG_W - sideband tag width
//
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset (release must be synchronised
//                externally)
//   flush   in   synchronous; drops every buffered entry and any entry
//                offered in the same cycle
//   bus     slave modport of imm_gen_pipe_if (handshakes, data, tag)
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    localparam logic [2:0] SEL_I     = 3'b000;
    localparam logic [2:0] SEL_S     = 3'b001;
    localparam logic [2:0] SEL_B     = 3'b010;
    localparam logic [2:0] SEL_U     = 3'b011;
    localparam logic [2:0] SEL_J     = 3'b100;
    localparam logic [2:0] SEL_SHAMT = 3'b101;
    localparam logic [2:0] SEL_CSRZ  = 3'b110;

    // Occupancy encoded directly as {sk_valid, or_valid}; 2'b10 cannot occur
    // because the skid register only fills while the output register is full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t           cur_state;

    logic             or_valid_q, or_valid_d;
    logic             sk_valid_q, sk_valid_d;
    logic             in_ready_q;

    logic [XLEN-1:0]  or_imm_q,  sk_imm_q;
    logic [TAG_W-1:0] or_tag_q,  sk_tag_q;
    logic             or_err_q,  sk_err_q;

    logic             accept;
    logic             handoff;
    logic             load_or;
    logic             load_sk;
    logic             move_sk;

    logic [63:0]      imm_wide;
    logic [XLEN-1:0]  imm_next;
    logic             err_next;
    logic             sign_bit;

    logic             unused_bits;

    // The opcode field is never inspected and the upper half of the wide
    // immediate is dropped when XLEN=32.
    assign unused_bits = ^{bus.instruction[6:0], imm_wide};

    // Immediate extraction. Everything is built at 64 bits with the sign bit
    // replicated, then truncated to XLEN. This naturally gives U-type its
    // "sign extend above bit 31 only on RV64" behaviour.
    always_comb begin
        imm_wide = '0;
        err_next = 1'b0;
        sign_bit = bus.instruction[31];
        case (bus.imm_sel)
            SEL_I: imm_wide = {{52{sign_bit}}, bus.instruction[31:20]};
            SEL_S: imm_wide = {{52{sign_bit}}, bus.instruction[31:25],
                               bus.instruction[11:7]};
            SEL_B: imm_wide = {{52{sign_bit}}, bus.instruction[7],
                               bus.instruction[30:25], bus.instruction[11:8],
                               1'b0};
            SEL_U: imm_wide = {{32{sign_bit}}, bus.instruction[31:12], 12'h000};
            SEL_J: imm_wide = {{44{sign_bit}}, bus.instruction[19:12],
                               bus.instruction[20], bus.instruction[30:21],
                               1'b0};
            SEL_SHAMT: begin
                // On RV32 bit 25 must be zero for a legal shift; report it
                // instead of folding it into the amount.
                if (XLEN == 32) begin
                    imm_wide = {59'd0, bus.instruction[24:20]};
                    err_next = bus.instruction[25];
                end else begin
                    imm_wide = {58'd0, bus.instruction[25:20]};
                end
            end
            SEL_CSRZ: imm_wide = {59'd0, bus.instruction[19:15]};
            default:  imm_wide = '0;
        endcase
    end

    assign imm_next = imm_wide[XLEN-1:0];

    assign accept  = bus.in_valid && in_ready_q;
    assign handoff = or_valid_q && bus.out_ready;

    // Next-state and datapath steering for the skid buffer. Flush overrides
    // everything: both valid bits drop and nothing is loaded.
    always_comb begin
        cur_state  = state_t'({sk_valid_q, or_valid_q});
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        load_or    = 1'b0;
        load_sk    = 1'b0;
        move_sk    = 1'b0;
        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else begin
            case (cur_state)
                ST_EMPTY: begin
                    if (accept) begin
                        or_valid_d = 1'b1;
                        load_or    = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && handoff) begin
                        load_or = 1'b1;
                    end else if (accept) begin
                        sk_valid_d = 1'b1;
                        load_sk    = 1'b1;
                    end else if (handoff) begin
                        or_valid_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (handoff) begin
                        sk_valid_d = 1'b0;
                        move_sk    = 1'b1;
                    end
                end
                default: begin
                    or_valid_d = 1'b0;
                    sk_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Valid bits plus a dedicated in_ready flop, so in_ready never has a
    // combinational path from out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
            in_ready_q <= !sk_valid_d;
        end
    end

    // Output register: new data when the buffer streams straight through,
    // otherwise the skid entry moves up when the consumer drains the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            or_imm_q <= '0;
            or_tag_q <= '0;
            or_err_q <= 1'b0;
        end else if (load_or) begin
            or_imm_q <= imm_next;
            or_tag_q <= bus.tag_in;
            or_err_q <= err_next;
        end else if (move_sk) begin
            or_imm_q <= sk_imm_q;
            or_tag_q <= sk_tag_q;
            or_err_q <= sk_err_q;
        end
    end

    // Skid register: catches the entry accepted while the head is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sk_imm_q <= '0;
            sk_tag_q <= '0;
            sk_err_q <= 1'b0;
        end else if (load_sk) begin
            sk_imm_q <= imm_next;
            sk_tag_q <= bus.tag_in;
            sk_err_q <= err_next;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = or_valid_q;
    assign bus.imm_out   = or_imm_q;
    assign bus.tag_out   = or_tag_q;
    assign bus.shamt_err = or_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Purpose: self-checking bench for imm_gen_pipe. Two instances (XLEN=32 and
// XLEN=64) receive identical stimulus; a behavioural reference model fills a
// scoreboard queue per instance on every accept and a monitor compares the
// head of the queue with the DUT output every cycle.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    typedef struct packed {
        logic        err;
        logic [63:0] imm;
        logic [31:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] tag;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    exp_t        q32[$];
    exp_t        q64[$];
    logic [31:0] log32[$];

    exp_t        f32, f64, e32, e64;
    logic [64:0] r32, r64;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) if64 ();

    assign if32.in_valid    = in_valid;
    assign if32.instruction = instr;
    assign if32.imm_sel     = sel;
    assign if32.tag_in      = tag;
    assign if32.out_ready   = out_ready;
    assign if64.in_valid    = in_valid;
    assign if64.instruction = instr;
    assign if64.imm_sel     = sel;
    assign if64.tag_in      = tag;
    assign if64.out_ready   = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(if32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(if64.slave)
    );

    // Reference model: immediate value as a signed integer, then reduced to
    // the machine width. Returns {shamt_err, imm}.
    function automatic logic [64:0] ref_model(input int xlen,
                                              input logic [31:0] ins,
                                              input logic [2:0] s);
        longint      v;
        logic        e;
        logic [63:0] r;
        v = 0;
        e = 1'b0;
        case (s)
            3'd0: v = longint'($signed(ins[31:20]));
            3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = longint'($signed({ins[31:12], 12'h000}));
            3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd5: begin
                if (xlen == 32) begin
                    v = longint'(ins[24:20]);
                    e = ins[25];
                end else begin
                    v = longint'(ins[25:20]);
                end
            end
            3'd6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        r = v;
        if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return {e, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic check_side(input string nm, input logic ov, input logic ir,
                              input logic [63:0] imm, input logic [31:0] tg,
                              input logic err, input int n, input exp_t front);
        chk({nm, ".out_valid"}, 64'(ov), 64'(n > 0));
        chk({nm, ".in_ready"},  64'(ir), 64'(n < 2));
        if (n > 0 && ov) begin
            chk({nm, ".imm_out"},   imm, front.imm);
            chk({nm, ".tag_out"},   64'(tg), 64'(front.tag));
            chk({nm, ".shamt_err"}, 64'(err), 64'(front.err));
        end
    endtask

    // Monitor / scoreboard: compare the current DUT state with the queue,
    // then retire the head on handoff and enqueue on accept.
    always @(negedge clk) begin
        if (!reset_n) begin
            q32.delete();
            q64.delete();
        end else begin
            f32 = (q32.size() > 0) ? q32[0] : '0;
            f64 = (q64.size() > 0) ? q64[0] : '0;
            check_side("x32", if32.out_valid, if32.in_ready, 64'(if32.imm_out),
                       if32.tag_out, if32.shamt_err, q32.size(), f32);
            check_side("x64", if64.out_valid, if64.in_ready, if64.imm_out,
                       if64.tag_out, if64.shamt_err, q64.size(), f64);
            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (if32.out_valid && out_ready && q32.size() > 0) begin
                    log32.push_back(q32[0].tag);
                    void'(q32.pop_front());
                end
                if (if64.out_valid && out_ready && q64.size() > 0)
                    void'(q64.pop_front());
                if (in_valid && if32.in_ready) begin
                    r32 = ref_model(32, instr, sel);
                    e32.err = r32[64]; e32.imm = r32[63:0]; e32.tag = tag;
                    q32.push_back(e32);
                end
                if (in_valid && if64.in_ready) begin
                    r64 = ref_model(64, instr, sel);
                    e64.err = r64[64]; e64.imm = r64[63:0]; e64.tag = tag;
                    q64.push_back(e64);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [31:0] ins, input logic [2:0] s,
                                 input logic [31:0] t);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        instr    = ins;
        sel      = s;
        tag      = t;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = if32.in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout got=in_ready_low expected=accept tag=0x%0h", t);
        end
    endtask

    // Directed vector: one cycle after acceptance the result must sit in the
    // output register of both instances.
    task automatic checkOutput(input string nm, input logic [31:0] ins,
                               input logic [2:0] s, input logic [31:0] t,
                               input logic [63:0] x32, input logic x32e,
                               input logic [63:0] x64, input logic x64e);
        applyStimulus(ins, s, t);
        chk({nm, ".v32"},   64'(if32.out_valid), 64'd1);
        chk({nm, ".imm32"}, 64'(if32.imm_out), x32);
        chk({nm, ".err32"}, 64'(if32.shamt_err), 64'(x32e));
        chk({nm, ".tag32"}, 64'(if32.tag_out), 64'(t));
        chk({nm, ".imm64"}, if64.imm_out, x64);
        chk({nm, ".err64"}, 64'(if64.shamt_err), 64'(x64e));
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, ".out_valid32"}, 64'(if32.out_valid), 64'd0);
        chk({nm, ".in_ready32"},  64'(if32.in_ready),  64'd1);
        chk({nm, ".imm32"},       64'(if32.imm_out),   64'd0);
        chk({nm, ".tag32"},       64'(if32.tag_out),   64'd0);
        chk({nm, ".err32"},       64'(if32.shamt_err), 64'd0);
        chk({nm, ".out_valid64"}, 64'(if64.out_valid), 64'd0);
        chk({nm, ".in_ready64"},  64'(if64.in_ready),  64'd1);
        chk({nm, ".imm64"},       if64.imm_out,        64'd0);
    endtask

    initial begin
        #300000;
        failures++;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        sel       = '0;
        tag       = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Directed format vectors
        out_ready = 1'b1;
        checkOutput("i_addi", 32'hFFF00093, 3'd0, 32'h100,
                    64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        checkOutput("s_sw",   32'hFE112E23, 3'd1, 32'h104,
                    64'hFFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        checkOutput("b_neg",  32'hFE000EE3, 3'd2, 32'h108,
                    64'hFFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        checkOutput("u_pos",  32'h123450B7, 3'd3, 32'h10C,
                    64'h1234_5000, 1'b0, 64'h0000_0000_1234_5000, 1'b0);
        checkOutput("u_neg",  32'h800000B7, 3'd3, 32'h110,
                    64'h8000_0000, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        checkOutput("j_jal",  32'h001000EF, 3'd4, 32'h114,
                    64'h0000_0800, 1'b0, 64'h0000_0000_0000_0800, 1'b0);
        checkOutput("shamt",  32'h02009093, 3'd5, 32'h118,
                    64'h0, 1'b1, 64'h20, 1'b0);
        checkOutput("csr_z",  32'h000F8073, 3'd6, 32'h11C,
                    64'h1F, 1'b0, 64'h1F, 1'b0);
        checkOutput("none",   32'hFFFFFFFF, 3'd7, 32'h120,
                    64'h0, 1'b0, 64'h0, 1'b0);
        repeat (2) tick();

        // Backpressure: A and B fill the buffer, C waits, then drain in order
        log32.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00100093;
        sel       = 3'd0;
        tag       = 32'hA;
        tick();
        tag = 32'hB;
        tick();
        chk("bp.in_ready_after_b", 64'(if32.in_ready), 64'd0);
        tag = 32'hC;
        repeat (2) tick();
        chk("bp.c_held", 64'(if32.in_ready), 64'd0);
        chk("bp.head_a", 64'(if32.tag_out), 64'hA);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (if32.in_ready) begin
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("bp.count", 64'(log32.size()), 64'd3);
        if (log32.size() == 3) begin
            chk("bp.order0", 64'(log32[0]), 64'hA);
            chk("bp.order1", 64'(log32[1]), 64'hB);
            chk("bp.order2", 64'(log32[2]), 64'hC);
        end

        // Flush while FULL with a simultaneous input
        log32.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tag       = 32'h1A;
        tick();
        tag = 32'h1B;
        tick();
        flush = 1'b1;
        tag   = 32'h1D;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_full.out_valid", 64'(if32.out_valid), 64'd0);
        chk("flush_full.in_ready",  64'(if32.in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_full.nothing_out", 64'(log32.size()), 64'd0);

        // Flush while ONE: the accept offered in the flush cycle is dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tag       = 32'h2A;
        tick();
        flush = 1'b1;
        tag   = 32'h2E;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_one.out_valid", 64'(if32.out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_one.nothing_out", 64'(log32.size()), 64'd0);
        applyStimulus(32'h00200093, 3'd0, 32'h2F);
        repeat (2) tick();
        chk("flush_one.next_count", 64'(log32.size()), 64'd1);
        if (log32.size() == 1) chk("flush_one.next_tag", 64'(log32[0]), 64'h2F);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tag       = 32'h3A;
        tick();
        tag = 32'h3B;
        tick();
        tag = 32'h3C;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        in_valid = 1'b0;
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        applyStimulus(32'h123450B7, 3'd3, 32'h3F);
        chk("post_reset.out_valid", 64'(if32.out_valid), 64'd1);
        chk("post_reset.tag", 64'(if32.tag_out), 64'h3F);
        chk("post_reset.imm", 64'(if32.imm_out), 64'h1234_5000);

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = $urandom;
            sel       = 3'($urandom_range(0, 7));
            tag       = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("drain.q32_empty", 64'(q32.size()), 64'd0);
        chk("drain.q64_empty", 64'(q64.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage of the pipelined core. It extracts and extends every RV32I/RV64I immediate format, including U-type, shift amounts and CSR zimm, to XLEN bits. It carries a caller-defined tag alongside each result through a 2-entry skid buffer with valid/ready handshakes. It sits between the fetch/decode register and the ID/EX register, and supports stall and flush.

## Interface
- XLEN, 32: datapath width. Legal values are 32 and 64.
- TAG_W, 32: width of the sideband tag carried with each result, typically PC.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous; discards all buffered entries.
- In_Valid  in  1  Instruction, Imm_Sel and Tag_In are valid.
- In_Ready  out  1  block can accept an entry this cycle. Registered.
- Instruction  in  32  raw instruction word.
- Imm_Sel  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110 CSR_Z, 111 NONE.
- Tag_In  in  TAG_W  sideband tag, passed through unmodified.
- Out_Valid  out  1  Imm_Out, Tag_Out and Shamt_Err are valid.
- Out_Ready  in  1  consumer accepts the output this cycle.
- Imm_Out  out  XLEN  extended immediate.
- Tag_Out  out  TAG_W  tag associated with Imm_Out.
- Shamt_Err  out  1  SHAMT select with an illegal shift amount for XLEN=32.

## Operation
- Extension. S = Instruction[31] is replicated to XLEN.
  - I: {S.., I[30:20]}
  - S: {S.., I[30:25], I[11:7]}
  - B: {S.., I[7], I[30:25], I[11:8], 0}
  - U: {S.., I[31:12], 12'b0}. Sign extension applies above bit 31 only when XLEN=64.
  - J: {S.., I[19:12], I[20], I[30:21], 0}
- SHAMT:
  - XLEN=32: zero-extended I[24:20]. Shamt_Err = I[25].
  - XLEN=64: zero-extended I[25:20]. Shamt_Err = 0.
- CSR_Z: zero-extended I[19:15].
- NONE: all zeros.
- Shamt_Err is 0 for every select other than SHAMT.
- The immediate is computed only from Imm_Sel and Instruction; the block does no funct3/opcode sniffing. The decoder is responsible for choosing SHAMT versus I.
- Storage:
  - Output register (OR): drives Imm_Out, Tag_Out, Shamt_Err and Out_Valid.
  - Skid register (SK): one entry.
- An accept happens when In_Valid && In_Ready.
- A handoff happens when Out_Valid && Out_Ready.
- States, derived from the valid bits:
  - EMPTY (OR empty, SK empty): accept → ONE.
  - ONE (OR full, SK empty):
    - accept and handoff → ONE, new data loaded into OR.
    - accept, no handoff → FULL, new data loaded into SK.
    - handoff only → EMPTY.
  - FULL (OR full, SK full): In_Ready = 0.
    - handoff → ONE, SK moves into OR.
    - no handoff → hold.
- In_Ready = !SK_valid, taken from a flop. Never combinational from Out_Ready.
- Output ordering is strict FIFO.
- Flush: on the next edge both valid bits clear. Any accept in the same cycle is dropped; flush wins over accept and handoff. The data registers need not clear.
- Output data stays stable while Out_Valid && !Out_Ready.

## Timing
- Reset values (Reset_n low, asynchronous): Out_Valid=0, SK_valid=0, In_Ready=1, Imm_Out=0, Tag_Out=0, Shamt_Err=0.
- Latency: 1 cycle. A result accepted at edge N appears with Out_Valid=1 after edge N.
- Throughput: 1 per cycle while Out_Ready=1.
- Under stall, at most 2 entries are held. In_Ready drops the cycle after SK fills and rises the cycle after SK drains.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Deasserting Reset_n has effect at the next edge. It must be synchronised externally.
- Flush during FULL: Out_Valid=0 and In_Ready=1 after the edge.

## Test plan
- XLEN=32, I-type:
  - 0xFFF00093 (addi x1,x0,-1) with tag 0x100 → one cycle later Imm_Out=0xFFFFFFFF, Tag_Out=0x100.
  - B-type 0xFE000EE3 → Imm_Out=0xFFFFFFFC.
- U-type:
  - XLEN=32, 0x123450B7 → 0x12345000.
  - XLEN=64, 0x800000B7 → 0xFFFFFFFF80000000.
  - J-type 0x001000EF → 0x00000800.
- SHAMT with 0x02009093:
  - XLEN=32 → Imm_Out=0x0, Shamt_Err=1.
  - XLEN=64 → Imm_Out=0x20, Shamt_Err=0.
  - CSR_Z with I[19:15]=0x1F → 0x1F.
- Backpressure:
  - Out_Ready=0, then three back-to-back inputs with tags A, B, C.
  - Required: A and B accepted; In_Ready=0 from the cycle after B; C held.
  - Raise Out_Ready: outputs A, B, C in order, one per cycle, no loss or duplication.
- Flush:
  - Fill to FULL, then pulse Flush together with In_Valid=1.
  - Next cycle: Out_Valid=0, In_Ready=1, and the flushed-cycle input never appears.
- Reset:
  - Assert Reset_n low mid-stream while FULL.
  - Required: outputs go to their reset values immediately, without a clock edge.
  - After release, the first new input appears with latency 1.
